// File: rtl/dmac_ahb_pkg.sv
// Shared AHB-Lite encodings, register selectors and data-phase states for the
// DMAC peripheral-side receive block.
package dmac_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    REG_DATA   = 2'b00,
    REG_STATUS = 2'b01,
    REG_THRESH = 2'b10,
    REG_RSVD   = 2'b11
  } reg_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
    ST_WAIT = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } dphase_e;

  function automatic logic trans_active(input logic [1:0] htrans);
    case (htrans)
      HTRANS_IDLE, HTRANS_BUSY: return 1'b0;
      HTRANS_NONSEQ, HTRANS_SEQ: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; DEPTH must be a power of
// two so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dmac_rx_peripheral.sv
// AHB-Lite slave that buffers producer words and serves them to the DMAC via
// a popping DATA register, raising a level DMA request at a programmable fill.
module dmac_rx_peripheral
  import dmac_ahb_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter logic [15:0] THRESH_RST = 16'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HSel,
  input  logic [31:0] HAddr,
  input  logic [1:0]  HTrans,
  input  logic        HWrite,
  input  logic [2:0]  HSize,
  input  logic        HReadyIn,
  input  logic [31:0] HWData,
  output logic [31:0] HRData,
  output logic        HReadyOut,
  output logic [1:0]  HResp,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        DmacReq,
  input  logic        ReqAck
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  dphase_e       state_q, state_d;
  reg_sel_e      reg_q;
  logic          write_q, size_ok_q;
  logic [15:0]   thresh_q, thresh_eff;
  logic          req_q, req_d, armed_q, armed_d;
  logic [31:0]   head;
  logic [CW-1:0] count;
  logic [15:0]   count16;
  logic          full, empty, push, pop;
  logic          take, illegal, in_dphase, data_rd, thresh_we, at_thresh;
  logic          unused_bits;

  assign unused_bits = ^{HAddr[31:4], HAddr[1:0], HWData[31:16]};
  assign count16     = 16'(count);
  assign push        = in_valid && !full;
  assign in_ready    = !full;
  assign DmacReq     = req_q;
  assign in_dphase   = (state_q == ST_DATA) || (state_q == ST_WAIT);
  assign data_rd     = in_dphase && !write_q && size_ok_q && (reg_q == REG_DATA);
  assign illegal     = (HSize != HSIZE_WORD) ||
                       (HWrite && ((HAddr[3:2] == REG_DATA) || (HAddr[3:2] == REG_STATUS)));

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (in_data),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Illegal accesses are classified at acceptance so the data phase opens
  // directly in ERR1 and never completes with OKAY.
  always_comb begin
    state_d   = state_q;
    HReadyOut = 1'b1;
    HResp     = HRESP_OKAY;
    pop       = 1'b0;
    thresh_we = 1'b0;
    case (state_q)
      ST_DATA, ST_WAIT: begin
        if (data_rd && empty) begin
          HReadyOut = 1'b0;
          state_d   = ST_WAIT;
        end else begin
          pop       = data_rd;
          thresh_we = write_q && size_ok_q && (reg_q == REG_THRESH);
          state_d   = ST_IDLE;
        end
      end
      ST_ERR1: begin
        HReadyOut = 1'b0;
        HResp     = HRESP_ERROR;
        state_d   = ST_ERR2;
      end
      ST_ERR2: begin
        HResp   = HRESP_ERROR;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    take = HReadyOut && HSel && HReadyIn && trans_active(HTrans);
    if (take) state_d = illegal ? ST_ERR1 : ST_DATA;
  end

  always_comb begin
    HRData = '0;
    if (in_dphase && !write_q && size_ok_q) begin
      case (reg_q)
        REG_DATA:   if (!empty) HRData = head;
        REG_STATUS: HRData = {13'd0, req_q, full, empty, count16};
        REG_THRESH: HRData = {16'd0, thresh_q};
        default:    HRData = '0;
      endcase
    end
  end

  // Ack has priority; re-arming needs the fill to fall below threshold.
  always_comb begin
    thresh_eff = (thresh_q == '0) ? 16'd1 : thresh_q;
    at_thresh  = (count16 >= thresh_eff);
    req_d      = req_q;
    armed_d    = armed_q;
    if (ReqAck) begin
      req_d   = 1'b0;
      armed_d = 1'b0;
    end else begin
      if (armed_q && at_thresh) req_d = 1'b1;
      if (!at_thresh) armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      reg_q     <= REG_DATA;
      write_q   <= 1'b0;
      size_ok_q <= 1'b0;
      thresh_q  <= THRESH_RST;
      req_q     <= 1'b0;
      armed_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      if (take) begin
        reg_q     <= reg_sel_e'(HAddr[3:2]);
        write_q   <= HWrite;
        size_ok_q <= (HSize == HSIZE_WORD);
      end
      if (thresh_we) thresh_q <= HWData[15:0];
      req_q   <= req_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: tb/tb_dmac_rx_peripheral.sv
// Directed bench for dmac_rx_peripheral: inputs change and outputs are
// sampled on the falling clock edge.
module tb_dmac_rx_peripheral;

  logic        clk = 1'b0;
  logic        rst;
  logic        HSel;
  logic [31:0] HAddr;
  logic [1:0]  HTrans;
  logic        HWrite;
  logic [2:0]  HSize;
  logic        HReadyIn;
  logic [31:0] HWData;
  logic [31:0] HRData;
  logic        HReadyOut;
  logic [1:0]  HResp;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        DmacReq;
  logic        ReqAck;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] rd;
  logic [1:0]  rsp, rsp0;
  int          waits;

  always #5 clk = ~clk;
  assign HReadyIn = HReadyOut;

  dmac_rx_peripheral #(.DEPTH(16), .THRESH_RST(16'd4)) dut (
    .clk       (clk),
    .rst       (rst),
    .HSel      (HSel),
    .HAddr     (HAddr),
    .HTrans    (HTrans),
    .HWrite    (HWrite),
    .HSize     (HSize),
    .HReadyIn  (HReadyIn),
    .HWData    (HWData),
    .HRData    (HRData),
    .HReadyOut (HReadyOut),
    .HResp     (HResp),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .DmacReq   (DmacReq),
    .ReqAck    (ReqAck)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Single transfer; returns at the negedge of the completing data-phase cycle.
  task automatic ahb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                          input logic [2:0] sz, output logic [31:0] rdata,
                          output logic [1:0] resp, output int nwait, output logic [1:0] resp_first);
    @(negedge clk);
    HSel = 1'b1; HTrans = 2'b10; HAddr = addr; HWrite = wr; HSize = sz;
    @(negedge clk);
    HSel = 1'b0; HTrans = 2'b00; HWData = wd;
    nwait = 0;
    resp_first = HResp;
    while (!HReadyOut && nwait < 64) begin
      @(negedge clk);
      nwait++;
    end
    rdata = HRData;
    resp  = HResp;
  endtask

  task automatic push_word(input logic [31:0] d);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_data = d;
    n = 0;
    while (!in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check("push_timeout", 32'(n), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge clk); ReqAck = 1'b1;
    @(negedge clk); ReqAck = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; HSel = 1'b0; HAddr = '0; HTrans = 2'b00; HWrite = 1'b0; HSize = 3'b010;
    HWData = '0; in_valid = 1'b0; in_data = '0; ReqAck = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hready", 32'(HReadyOut), 32'd1);
    check("rst_hresp", 32'(HResp), 32'd0);
    check("rst_hrdata", HRData, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_req", 32'(DmacReq), 32'd0);
    rst = 1'b0;
    ahb_xfer(32'h4, 1'b0, '0, 3'b010, rd, rsp, waits, rsp0);
    check("rst_status", rd, 32'h0001_0000);
    ahb_xfer(32'h8, 1'b0, '0, 3'b010, rd, rsp, waits, rsp0);
    check("rst_thresh", rd, 32'd4);

    // Threshold request, ack, then a pipelined 4-beat read burst
    for (int i = 0; i < 4; i++) push_word(32'hA1 + 32'(i));
    check("req_before", 32'(DmacReq), 32'd0);
    @(negedge clk);
    check("req_rise", 32'(DmacReq), 32'd1);
    ReqAck = 1'b1;
    @(negedge clk);
    ReqAck = 1'b0;
    check("req_acked", 32'(DmacReq), 32'd0);
    @(negedge clk);
    check("req_held_low", 32'(DmacReq), 32'd0);
    HSel = 1'b1; HTrans = 2'b10; HAddr = 32'h0; HWrite = 1'b0; HSize = 3'b010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) HTrans = 2'b11;
      else begin HSel = 1'b0; HTrans = 2'b00; end
      check("burst_ready", 32'(HReadyOut), 32'd1);
      check("burst_data", HRData, 32'hA1 + 32'(i));
    end
    ahb_xfer(32'h4, 1'b0, '0, 3'b010, rd, rsp, waits, rsp0);
    check("burst_status", rd, 32'h0001_0000);

    // Read of empty FIFO stalls until a late push lands
    fork
      ahb_xfer(32'h0, 1'b0, '0, 3'b010, rd, rsp, waits, rsp0);
      begin repeat (5) @(negedge clk); push_word(32'h55); end
    join
    check("wait_cycles", 32'(waits), 32'd5);
    check("wait_data", rd, 32'h55);
    check("wait_resp", 32'(rsp), 32'd0);
    check("wait_resp_first", 32'(rsp0), 32'd0);

    // Illegal accesses: two-cycle ERROR, no side effects
    ahb_xfer(32'h0, 1'b1, 32'hDEAD, 3'b010, rd, rsp, waits, rsp0);
    check("werr0_waits", 32'(waits), 32'd1);
    check("werr0_resp1", 32'(rsp0), 32'd1);
    check("werr0_resp2", 32'(rsp), 32'd1);
    ahb_xfer(32'h4, 1'b1, 32'hFFFF_FFFF, 3'b010, rd, rsp, waits, rsp0);
    check("werr4_waits", 32'(waits), 32'd1);
    check("werr4_resp1", 32'(rsp0), 32'd1);
    check("werr4_resp2", 32'(rsp), 32'd1);
    ahb_xfer(32'h8, 1'b1, 32'h9, 3'b000, rd, rsp, waits, rsp0);
    check("size_err_resp", 32'(rsp), 32'd1);
    ahb_xfer(32'hC, 1'b1, 32'h1234, 3'b010, rd, rsp, waits, rsp0);
    check("rsvd_wr_resp", {30'd0, rsp} | 32'(waits), 32'd0);
    ahb_xfer(32'hC, 1'b0, '0, 3'b010, rd, rsp, waits, rsp0);
    check("rsvd_rd", rd, 32'd0);
    ahb_xfer(32'h4, 1'b0, '0, 3'b010, rd, rsp, waits, rsp0);
    check("err_status", rd, 32'h0001_0000);
    ahb_xfer(32'h8, 1'b0, '0, 3'b010, rd, rsp, waits, rsp0);
    check("err_thresh", rd, 32'd4);

    // Fill to full, then pop+push across the pointer wrap
    for (int i = 0; i < 16; i++) push_word(32'h100 + 32'(i));
    check("full_in_ready", 32'(in_ready), 32'd0);
    ahb_xfer(32'h4, 1'b0, '0, 3'b010, rd, rsp, waits, rsp0);
    check("full_status", rd, 32'h0006_0010);
    fork
      ahb_xfer(32'h0, 1'b0, '0, 3'b010, rd, rsp, waits, rsp0);
      push_word(32'hBEEF);
    join
    check("full_pop_data", rd, 32'h100);
    check("full_pop_waits", 32'(waits), 32'd0);
    ahb_xfer(32'h4, 1'b0, '0, 3'b010, rd, rsp, waits, rsp0);
    check("wrap_status", rd, 32'h0006_0010);
    for (int i = 1; i < 17; i++) begin
      ahb_xfer(32'h0, 1'b0, '0, 3'b010, rd, rsp, waits, rsp0);
      check("drain", rd, (i < 16) ? 32'h100 + 32'(i) : 32'hBEEF);
    end
    ahb_xfer(32'h4, 1'b0, '0, 3'b010, rd, rsp, waits, rsp0);
    check("drain_status", rd, 32'h0005_0000);

    // THRESH=0 behaves as 1; re-arm only after count falls below it
    pulse_ack();
    check("thr0_ack", 32'(DmacReq), 32'd0);
    ahb_xfer(32'h8, 1'b1, 32'h0, 3'b010, rd, rsp, waits, rsp0);
    check("thr0_wr_resp", {30'd0, rsp} | 32'(waits), 32'd0);
    ahb_xfer(32'h8, 1'b0, '0, 3'b010, rd, rsp, waits, rsp0);
    check("thr0_rd", rd, 32'd0);
    push_word(32'h77);
    @(negedge clk);
    check("thr0_req", 32'(DmacReq), 32'd1);
    pulse_ack();
    check("thr0_acked", 32'(DmacReq), 32'd0);
    repeat (3) @(negedge clk);
    check("thr0_no_rearm", 32'(DmacReq), 32'd0);
    ahb_xfer(32'h0, 1'b0, '0, 3'b010, rd, rsp, waits, rsp0);
    check("thr0_pop", rd, 32'h77);
    push_word(32'h78);
    @(negedge clk);
    check("thr0_rearm_req", 32'(DmacReq), 32'd1);

    // Reset in the middle of a WAIT data phase
    ahb_xfer(32'h0, 1'b0, '0, 3'b010, rd, rsp, waits, rsp0);
    check("pre_rst_pop", rd, 32'h78);
    @(negedge clk);
    HSel = 1'b1; HTrans = 2'b10; HAddr = 32'h0; HWrite = 1'b0; HSize = 3'b010;
    @(negedge clk);
    HSel = 1'b0; HTrans = 2'b00;
    check("wait_low_a", 32'(HReadyOut), 32'd0);
    @(negedge clk);
    check("wait_low_b", 32'(HReadyOut), 32'd0);
    rst = 1'b1; in_valid = 1'b1; in_data = 32'h99;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check("rst_wait_hready", 32'(HReadyOut), 32'd1);
    check("rst_wait_req", 32'(DmacReq), 32'd0);
    check("rst_wait_in_ready", 32'(in_ready), 32'd1);
    ahb_xfer(32'h4, 1'b0, '0, 3'b010, rd, rsp, waits, rsp0);
    check("rst_wait_status", rd, 32'h0001_0000);
    ahb_xfer(32'h8, 1'b0, '0, 3'b010, rd, rsp, waits, rsp0);
    check("rst_wait_thresh", rd, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
